// File: rtl/data_sram_ctrl.sv
// Data-side SRAM-like bus controller for the MEM stage: launches one load/store,
// stalls MEM until it completes, and drains bus transactions cancelled by a flush.
module data_sram_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_req,
    input  logic        mem_wr,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic        flush,
    input  logic        wb_allowin,
    output logic        mem_stall,
    output logic        rdata_valid,
    output logic [31:0] rdata,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic        cancel;
    logic        cancel_next;
    logic        launch;
    logic        capture;
    logic [31:0] wdata_rep;

    always_comb begin
        case (mem_size)
            2'd0:    wdata_rep = {4{mem_wdata[7:0]}};
            2'd1:    wdata_rep = {2{mem_wdata[15:0]}};
            default: wdata_rep = mem_wdata;
        endcase
    end

    always_comb begin
        state_next  = state;
        cancel_next = cancel;
        launch      = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req && !flush) begin
                    launch     = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                // req cannot be withdrawn, so a flush only marks the transaction
                if (flush) cancel_next = 1'b1;
                if (data_addr_ok) state_next = WAIT;
            end
            WAIT: begin
                if (flush) cancel_next = 1'b1;
                if (data_data_ok) begin
                    if (cancel || flush) begin
                        cancel_next = 1'b0;
                        state_next  = IDLE;
                    end else begin
                        capture    = !data_wr;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (wb_allowin || flush) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cancel <= 1'b0;
        end else begin
            state  <= state_next;
            cancel <= cancel_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_wr    <= 1'b0;
            data_size  <= 2'd0;
            data_addr  <= 32'd0;
            data_wstrb <= 4'd0;
            data_wdata <= 32'd0;
        end else if (launch) begin
            data_wr    <= mem_wr;
            data_size  <= mem_size;
            data_addr  <= mem_addr;
            data_wstrb <= mem_wr ? mem_wstrb : 4'd0;
            data_wdata <= wdata_rep;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata <= 32'd0;
        end else if (capture) begin
            rdata <= data_rdata;
        end
    end

    assign data_req    = (state == REQ);
    assign rdata_valid = (state == DONE);
    assign mem_stall   = mem_req && !flush && !((state == DONE) && wb_allowin);

endmodule
